// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared widths and store-buffer entry type for the MIPS data-memory path
// Purpose: word-address/data widths matching DataMemory, and the packed {addr,data} entry
//          held by each store-buffer slot.
package mips_mem_pkg;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/store_write_buffer_if.sv
// rtl/store_write_buffer_if.sv - core-side and memory-side signals of the store write buffer
// Purpose: bundles the core store/load-lookup port and the DataMemory drain port.
// Ports (slave = buffer side):
//   in : cpu_wr_en, cpu_wr_addr, cpu_wr_data, cpu_rd_addr, mem_busy
//   out: cpu_stall, fwd_hit, fwd_data, mem_wr_en, mem_wr_addr, mem_wr_data, empty, count
interface store_write_buffer_if #(
    parameter int DEPTH = 4
);
    import mips_mem_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              cpu_wr_en;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_stall;
    logic [ADDR_W-1:0] cpu_rd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              mem_busy;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              empty;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  cpu_wr_en, cpu_wr_addr, cpu_wr_data, cpu_rd_addr, mem_busy,
        output cpu_stall, fwd_hit, fwd_data, mem_wr_en, mem_wr_addr, mem_wr_data, empty, count
    );

    modport master (
        output cpu_wr_en, cpu_wr_addr, cpu_wr_data, cpu_rd_addr, mem_busy,
        input  cpu_stall, fwd_hit, fwd_data, mem_wr_en, mem_wr_addr, mem_wr_data, empty, count
    );
endinterface

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - youngest-match selector for store-to-load forwarding
// Purpose: finds the most recently written valid entry whose address equals rd_addr.
// Ports:
//   entries  in  buffered {addr,data} slots
//   valid    in  per-slot valid bits
//   wr_ptr   in  next slot to be written (youngest entry sits just behind it)
//   rd_addr  in  load address to look up
//   hit      out any valid slot matches
//   data     out data of youngest matching slot, 0 when no hit
module sb_fwd_match
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  sb_entry_t                    entries [DEPTH],
    input  logic [DEPTH-1:0]             valid,
    input  logic [$clog2(DEPTH)-1:0]     wr_ptr,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk from oldest (wr_ptr - DEPTH == wr_ptr) to youngest (wr_ptr - 1) so the
    // last match assigned is the youngest, independent of physical slot order.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = wr_ptr - PTR_W'(k);
            if (valid[idx] && (entries[idx].addr == rd_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - posted-store FIFO between the core store port and DataMemory
// Purpose: accepts one store per cycle, drains one per cycle in program order, forwards
//          the youngest buffered data to loads, stalls the core only when full.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous reset, active-high; pending stores are discarded
//   bus  slave modport of store_write_buffer_if (core store/lookup + memory drain)
module store_write_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    store_write_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic full;
    logic is_empty;
    logic push;
    logic pop;

    // Full comes from the count alone, so a same-cycle pop never lets a push in.
    assign full     = (count == CNT_W'(DEPTH));
    assign is_empty = (count == '0);
    assign push     = bus.cpu_wr_en && !full;
    assign pop      = !is_empty && !bus.mem_busy;

    assign bus.cpu_stall   = full;
    assign bus.empty       = is_empty;
    assign bus.count       = count;
    assign bus.mem_wr_en   = pop;
    assign bus.mem_wr_addr = is_empty ? '0 : entries[rd_ptr].addr;
    assign bus.mem_wr_data = is_empty ? '0 : entries[rd_ptr].data;

    // Payload slots carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= '{addr: bus.cpu_wr_addr, data: bus.cpu_wr_data};
        end
    end

    // wr_ptr == rd_ptr only when empty or full, so push and pop never touch the same slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd_match (
        .entries (entries),
        .valid   (valid),
        .wr_ptr  (wr_ptr),
        .rd_addr (bus.cpu_rd_addr),
        .hit     (bus.fwd_hit),
        .data    (bus.fwd_data)
    );
endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - directed self-checking bench for store_write_buffer
module tb_store_write_buffer;
    import mips_mem_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] wr_log_addr [$];
    logic [DATA_W-1:0] wr_log_data [$];
    logic [ADDR_W-1:0] exp_addr [$];
    logic [DATA_W-1:0] exp_data [$];

    store_write_buffer_if #(.DEPTH(DEPTH)) bus ();

    store_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so negedge sees the values the next posedge acts on.
    always @(negedge clk) begin
        if (bus.mem_wr_en) begin
            wr_log_addr.push_back(bus.mem_wr_addr);
            wr_log_data.push_back(bus.mem_wr_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.cpu_wr_en   = 1'b1;
        bus.cpu_wr_addr = a;
        bus.cpu_wr_data = d;
        tick();
        bus.cpu_wr_en   = 1'b0;
    endtask

    task automatic clear_logs();
        wr_log_addr.delete();
        wr_log_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic compare_logs(input string tag);
        check({tag, "_nwrites"}, 64'(wr_log_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < wr_log_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(wr_log_addr[i]), 64'(exp_addr[i]));
            check($sformatf("%s_data%0d", tag, i), 64'(wr_log_data[i]), 64'(exp_data[i]));
        end
    endtask

    initial begin
        int n;
        bus.cpu_wr_en   = 1'b0;
        bus.cpu_wr_addr = '0;
        bus.cpu_wr_data = '0;
        bus.cpu_rd_addr = '0;
        bus.mem_busy    = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_stall", 64'(bus.cpu_stall), 64'd0);
        check("rst_mem_wr_en", 64'(bus.mem_wr_en), 64'd0);
        check("rst_fwd_hit", 64'(bus.fwd_hit), 64'd0);

        // 1: reset discards three pending entries
        clear_logs();
        bus.mem_busy = 1'b1;
        push_one(9'h001, 32'h11);
        push_one(9'h002, 32'h22);
        push_one(9'h003, 32'h33);
        check("t1_count_pre", 64'(bus.count), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t1_count", 64'(bus.count), 64'd0);
        check("t1_empty", 64'(bus.empty), 64'd1);
        bus.mem_busy = 1'b0;
        repeat (4) tick();
        check("t1_no_writes", 64'(wr_log_addr.size()), 64'd0);

        // 2: single store drains the cycle after it is pushed
        clear_logs();
        push_one(9'h010, 32'hDEADBEEF);
        check("t2_wr_en", 64'(bus.mem_wr_en), 64'd1);
        check("t2_addr", 64'(bus.mem_wr_addr), 64'h010);
        check("t2_data", 64'(bus.mem_wr_data), 64'hDEADBEEF);
        tick();
        check("t2_empty", 64'(bus.empty), 64'd1);
        check("t2_wr_en_off", 64'(bus.mem_wr_en), 64'd0);
        check("t2_addr_empty", 64'(bus.mem_wr_addr), 64'd0);

        // 3: five pushes into a busy memory; fifth held until space opens
        clear_logs();
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_one(9'h100 + 9'(i), 32'hA0 + 32'(i));
            exp_addr.push_back(9'h100 + 9'(i));
            exp_data.push_back(32'hA0 + 32'(i));
        end
        check("t3_stall", 64'(bus.cpu_stall), 64'd1);
        check("t3_wr_en_busy", 64'(bus.mem_wr_en), 64'd0);
        bus.cpu_wr_en   = 1'b1;
        bus.cpu_wr_addr = 9'h104;
        bus.cpu_wr_data = 32'hA4;
        tick();
        check("t3_held_count", 64'(bus.count), 64'd4);
        check("t3_head_stable", 64'(bus.mem_wr_addr), 64'h100);
        bus.mem_busy = 1'b0;
        n = 0;
        while (bus.cpu_stall && n < 20) begin
            tick();
            n++;
        end
        check("t3_stall_release", 64'(bus.cpu_stall), 64'd0);
        tick();
        bus.cpu_wr_en = 1'b0;
        exp_addr.push_back(9'h104);
        exp_data.push_back(32'hA4);
        repeat (8) tick();
        compare_logs("t3");

        // 5: full buffer with pop and push attempt in the same cycle
        clear_logs();
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_one(9'h200 + 9'(i), 32'hB0 + 32'(i));
            exp_addr.push_back(9'h200 + 9'(i));
            exp_data.push_back(32'hB0 + 32'(i));
        end
        bus.mem_busy    = 1'b0;
        bus.cpu_wr_en   = 1'b1;
        bus.cpu_wr_addr = 9'h2FF;
        bus.cpu_wr_data = 32'hBF;
        tick();
        check("t5_count_pop", 64'(bus.count), 64'd3);
        bus.mem_busy = 1'b1;
        tick();
        bus.cpu_wr_en = 1'b0;
        check("t5_count_push", 64'(bus.count), 64'd4);
        exp_addr.push_back(9'h2FF);
        exp_data.push_back(32'hBF);
        bus.mem_busy = 1'b0;
        repeat (6) tick();
        compare_logs("t5");

        // 4: forwarding; wr_ptr is 3 here so the two 0x020 stores straddle the wrap
        clear_logs();
        bus.mem_busy = 1'b1;
        push_one(9'h020, 32'h1);
        push_one(9'h020, 32'h2);
        bus.cpu_rd_addr = 9'h020;
        #1;
        check("t4_hit", 64'(bus.fwd_hit), 64'd1);
        check("t4_data_youngest", 64'(bus.fwd_data), 64'h2);
        bus.cpu_rd_addr = 9'h021;
        #1;
        check("t4_miss_hit", 64'(bus.fwd_hit), 64'd0);
        check("t4_miss_data", 64'(bus.fwd_data), 64'd0);
        bus.cpu_wr_en   = 1'b1;
        bus.cpu_wr_addr = 9'h030;
        bus.cpu_wr_data = 32'h3;
        bus.cpu_rd_addr = 9'h030;
        #1;
        check("t4_same_cycle_push", 64'(bus.fwd_hit), 64'd0);
        tick();
        bus.cpu_wr_en = 1'b0;
        check("t4_after_push_hit", 64'(bus.fwd_hit), 64'd1);
        check("t4_after_push_data", 64'(bus.fwd_data), 64'h3);
        // Head 0x020=1 is popping this cycle and must still be forwardable as the only
        // 0x020 match once the younger one is gone; here the younger copy wins.
        bus.cpu_rd_addr = 9'h020;
        bus.mem_busy    = 1'b0;
        #1;
        check("t4_pop_visible", 64'(bus.fwd_data), 64'h2);
        repeat (5) tick();
        check("t4_drained", 64'(bus.empty), 64'd1);
        check("t4_drained_hit", 64'(bus.fwd_hit), 64'd0);

        // 6: twelve pushes under random memory busy; write order equals push order
        clear_logs();
        n = 0;
        for (int i = 0; i < 12; i++) begin
            bus.cpu_wr_en   = 1'b1;
            bus.cpu_wr_addr = 9'h180 + 9'(i * 7);
            bus.cpu_wr_data = $urandom;
            exp_addr.push_back(bus.cpu_wr_addr);
            exp_data.push_back(bus.cpu_wr_data);
            forever begin
                bus.mem_busy = 1'($urandom_range(0, 1));
                #1;
                if (!bus.cpu_stall || n > 400) break;
                tick();
                n++;
            end
            tick();
            n++;
        end
        bus.cpu_wr_en = 1'b0;
        check("t6_no_timeout", 64'(n <= 400), 64'd1);
        bus.mem_busy = 1'b0;
        repeat (8) tick();
        compare_logs("t6");
        check("t6_empty", 64'(bus.empty), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
